// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Two-master round-robin arbiter for the native SoC memory bus. One whole
// transaction is granted at a time; the granted master's request is passed
// straight through to the slave fabric, and a watchdog forces completion of
// transactions that no slave ever answers.
module mem_bus_arbiter #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic        owner,
  output logic        busy,
  output logic        timeout,
  output logic [31:0] err_addr,
  output logic [7:0]  err_count
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t      state_reg, state_next;
  logic        owner_reg, owner_next;
  logic        last_reg, last_next;
  logic [15:0] cnt_reg;
  logic [31:0] err_addr_reg;
  logic [7:0]  err_count_reg;

  logic        own_valid;
  logic [31:0] own_addr;
  logic [31:0] own_wdata;
  logic [3:0]  own_wstrb;
  logic        force_done;
  logic        done;
  logic [31:0] done_rdata;

  // Select the current owner's request signals.
  always_comb begin
    own_valid = owner_reg ? m1_valid : m0_valid;
    own_addr  = owner_reg ? m1_addr  : m0_addr;
    own_wdata = owner_reg ? m1_wdata : m0_wdata;
    own_wstrb = owner_reg ? m1_wstrb : m0_wstrb;
  end

  // Bus pass-through, completion and forced-completion outputs.
  always_comb begin
    busy       = (state_reg == BUSY);
    // The watchdog fires only when enabled; s_valid is withdrawn that cycle
    // so a late slave ready cannot race the forced completion.
    force_done = busy && (TIMEOUT_CYCLES != 16'd0) && (cnt_reg == TIMEOUT_CYCLES);
    s_valid    = busy && own_valid && !force_done;
    s_addr     = busy ? own_addr  : 32'd0;
    s_wdata    = busy ? own_wdata : 32'd0;
    s_wstrb    = busy ? own_wstrb : 4'd0;
    done       = (s_valid && s_ready) || force_done;
    done_rdata = force_done ? TIMEOUT_RDATA : s_rdata;
    m0_ready   = done && !owner_reg;
    m1_ready   = done && owner_reg;
    m0_rdata   = m0_ready ? done_rdata : 32'd0;
    m1_rdata   = m1_ready ? done_rdata : 32'd0;
    timeout    = force_done;
    owner      = owner_reg;
    err_addr   = err_addr_reg;
    err_count  = err_count_reg;
  end

  // Next-state: round-robin grant in IDLE, completion or abort in BUSY.
  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    last_next  = last_reg;
    case (state_reg)
      IDLE: begin
        if (m0_valid && m1_valid) begin
          // Tie goes to whichever master was not served last.
          owner_next = ~last_reg;
          state_next = BUSY;
        end else if (m0_valid) begin
          owner_next = 1'b0;
          state_next = BUSY;
        end else if (m1_valid) begin
          owner_next = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (done) begin
          last_next  = owner_reg;
          state_next = IDLE;
        end else if (!own_valid) begin
          // Owner withdrew its request: drop the grant without a ready.
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, grant bookkeeping and the watchdog counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      owner_reg <= 1'b0;
      last_reg  <= 1'b1;
      cnt_reg   <= 16'd0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      last_reg  <= last_next;
      // Held at zero while idle, so every grant starts counting from zero.
      if (state_reg == IDLE) begin
        cnt_reg <= 16'd0;
      end else if (!done) begin
        cnt_reg <= cnt_reg + 16'd1;
      end
    end
  end

  // Error capture for forced completions; the count saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_addr_reg  <= 32'd0;
      err_count_reg <= 8'd0;
    end else if (force_done) begin
      err_addr_reg <= own_addr;
      if (err_count_reg != 8'hFF) begin
        err_count_reg <= err_count_reg + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: directed steps with a completion scoreboard.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_ready;
  logic [31:0] s_rdata;
  logic        owner, busy, timeout;
  logic [31:0] err_addr;
  logic [7:0]  err_count;

  // Slave model: directed drive, or zero-wait auto mode answering addr+1.
  logic        auto_slave;
  logic        s_ready_drv;
  logic [31:0] s_rdata_drv;

  always_comb begin
    s_ready = auto_slave ? 1'b1 : s_ready_drv;
    s_rdata = auto_slave ? (s_addr + 32'd1) : s_rdata_drv;
  end

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .TIMEOUT_CYCLES(16'd8),
    .TIMEOUT_RDATA (32'hFFFF_FFFF)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .owner(owner), .busy(busy), .timeout(timeout),
    .err_addr(err_addr), .err_count(err_count)
  );

  typedef struct {
    logic        mst;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic mst, input logic [31:0] data);
    exp_t e;
    e.mst  = mst;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Completion monitor: every master ready must match the next expected entry.
  always @(negedge clk) begin
    if (!rst) begin
      if (m0_ready || m1_ready) begin
        n_cmp++;
        assert (sb.size() > 0) else begin
          n_err++;
          $error("FAIL spurious_ready observed=%b%b expected=none", m1_ready, m0_ready);
        end
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("ready_master", {30'd0, m1_ready, m0_ready}, e.mst ? 32'd2 : 32'd1);
          chk("ready_rdata", e.mst ? m1_rdata : m0_rdata, e.data);
          $display("txn master=%0d rdata=%h", e.mst, e.mst ? m1_rdata : m0_rdata);
        end
      end
      if (!m0_ready) chk("m0_rdata_idle", m0_rdata, 32'd0);
      if (!m1_ready) chk("m1_rdata_idle", m1_rdata, 32'd0);
    end
  end

  initial begin
    int nd;
    rst = 1'b1;
    auto_slave = 1'b0; s_ready_drv = 1'b0; s_rdata_drv = 32'd0;
    m0_valid = 1'b0; m0_addr = 32'd0; m0_wdata = 32'd0; m0_wstrb = 4'd0;
    m1_valid = 1'b0; m1_addr = 32'd0; m1_wdata = 32'd0; m1_wstrb = 4'd0;

    // Reset state.
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_s_valid", s_valid, 0);
    chk("rst_owner", owner, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_err_addr", err_addr, 0);
    nxt();
    rst = 1'b0;

    // Single master read, slave ready on the third s_valid cycle.
    m0_valid = 1'b1; m0_addr = 32'h0000_0010;
    push(1'b0, 32'h1234_5678);
    @(negedge clk); chk("t1_idle_s_valid", s_valid, 0);
    nxt();
    @(negedge clk); chk("t1_s_valid_c1", s_valid, 1); chk("t1_owner", owner, 0);
    nxt();
    @(negedge clk); chk("t1_s_valid_c2", s_valid, 1); chk("t1_m0_ready_c2", m0_ready, 0);
    nxt();
    s_ready_drv = 1'b1; s_rdata_drv = 32'h1234_5678;
    @(negedge clk); chk("t1_s_valid_c3", s_valid, 1); chk("t1_m0_ready_c3", m0_ready, 1);
    nxt();
    m0_valid = 1'b0; s_ready_drv = 1'b0;
    @(negedge clk); chk("t1_after_s_valid", s_valid, 0); chk("t1_after_busy", busy, 0);
    nxt();

    // Round robin from reset with a zero-wait slave.
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    auto_slave = 1'b1;
    m0_valid = 1'b1; m0_addr = 32'h0000_0100;
    m1_valid = 1'b1; m1_addr = 32'h0000_0200;
    push(1'b0, 32'h0000_0101); push(1'b1, 32'h0000_0201);
    push(1'b0, 32'h0000_0101); push(1'b1, 32'h0000_0201);
    nd = 0;
    for (int c = 0; c < 20 && nd < 4; c++) begin
      @(negedge clk);
      if (busy) chk("rr_owner", owner, nd % 2);
      if (m0_ready || m1_ready) nd++;
      nxt();
    end
    m0_valid = 1'b0; m1_valid = 1'b0; auto_slave = 1'b0;
    chk("rr_grants", nd, 4);

    // Write pass-through from master 1.
    m1_valid = 1'b1; m1_addr = 32'h8001_0000; m1_wdata = 32'hA5A5_A5A5; m1_wstrb = 4'b0011;
    @(negedge clk);
    chk("wr_idle_addr", s_addr, 0); chk("wr_idle_wdata", s_wdata, 0); chk("wr_idle_wstrb", s_wstrb, 0);
    nxt();
    @(negedge clk);
    chk("wr_addr", s_addr, 32'h8001_0000); chk("wr_wdata", s_wdata, 32'hA5A5_A5A5);
    chk("wr_wstrb", s_wstrb, 4'b0011); chk("wr_owner", owner, 1);
    nxt();
    s_ready_drv = 1'b1; s_rdata_drv = 32'h0BAD_F00D;
    push(1'b1, 32'h0BAD_F00D);
    @(negedge clk); chk("wr_addr_c2", s_addr, 32'h8001_0000);
    nxt();
    m1_valid = 1'b0; m1_wstrb = 4'd0; s_ready_drv = 1'b0;
    @(negedge clk);
    chk("wr_after_addr", s_addr, 0); chk("wr_after_wdata", s_wdata, 0); chk("wr_after_wstrb", s_wstrb, 0);
    nxt();

    // Timeout: slave never answers.
    m0_valid = 1'b1; m0_addr = 32'h8004_0000;
    push(1'b0, 32'hFFFF_FFFF);
    @(negedge clk);
    nxt();
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk("to_pulse", timeout, (k == 9) ? 1 : 0);
      chk("to_s_valid", s_valid, (k == 9) ? 0 : 1);
      chk("to_m0_ready", m0_ready, (k == 9) ? 1 : 0);
      nxt();
      if (k == 9) m0_valid = 1'b0;
    end
    @(negedge clk);
    chk("to_err_addr", err_addr, 32'h8004_0000);
    chk("to_err_count", err_count, 1);
    chk("to_pulse_after", timeout, 0);
    chk("to_busy_after", busy, 0);
    nxt();

    // Boundary: slave ready on BUSY cycle 8 beats the watchdog.
    m0_valid = 1'b1; m0_addr = 32'h0000_0044;
    push(1'b0, 32'hCAFE_BABE);
    @(negedge clk);
    nxt();
    for (int k = 1; k <= 8; k++) begin
      s_ready_drv = (k == 8); s_rdata_drv = 32'hCAFE_BABE;
      @(negedge clk);
      chk("bd_no_timeout", timeout, 0);
      chk("bd_m0_ready", m0_ready, (k == 8) ? 1 : 0);
      nxt();
    end
    m0_valid = 1'b0; s_ready_drv = 1'b0;
    @(negedge clk);
    chk("bd_busy_after", busy, 0); chk("bd_err_count", err_count, 1);
    nxt();

    // Reset in the middle of a master 1 transaction.
    m1_valid = 1'b1; m1_addr = 32'h0000_0500;
    @(negedge clk);
    nxt();
    @(negedge clk);
    chk("mr_pre_s_valid", s_valid, 1); chk("mr_pre_owner", owner, 1);
    #1 rst = 1'b1;
    #1;
    chk("mr_s_valid", s_valid, 0); chk("mr_busy", busy, 0);
    chk("mr_m0_ready", m0_ready, 0); chk("mr_m1_ready", m1_ready, 0);
    chk("mr_owner", owner, 0); chk("mr_err_count", err_count, 0);
    nxt();
    m1_valid = 1'b0;
    nxt();
    rst = 1'b0;
    m0_valid = 1'b1; m0_addr = 32'h0000_0600;
    m1_valid = 1'b1; m1_addr = 32'h0000_0700;
    s_ready_drv = 1'b1; s_rdata_drv = 32'h0000_0077;
    push(1'b0, 32'h0000_0077);
    @(negedge clk); chk("mr_idle_busy", busy, 0);
    nxt();
    @(negedge clk); chk("mr_tie_owner", owner, 0);
    nxt();
    m0_valid = 1'b0; m1_valid = 1'b0; s_ready_drv = 1'b0;
    @(negedge clk); chk("mr_done_busy", busy, 0);
    nxt();
    nxt();
    chk("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard bound on simulation time.
  initial begin
    #200000;
    $display("FAIL watchdog observed=hang expected=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master arbiter for the native SoC memory bus: valid/ready, 32-bit addr/wdata/rdata, 4-bit wstrb. It lets the CPU core (master 0) and a DMA/debug master (master 1) share the single slave fabric: the RAM, gpio, uart and pwm decode. It grants one whole transaction at a time using round-robin priority. A timeout forces completion of transactions that no slave answers.

## Interface
- TIMEOUT_CYCLES, 16'd1024: busy cycles without slave ready before forced completion; 0 disables the timeout; maximum 65535.
- TIMEOUT_RDATA, 32'hFFFF_FFFF: read data returned on a forced completion.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- m0_valid, m1_valid  in  1  master request; held high until that master's ready.
- m0_addr, m1_addr  in  32  byte address.
- m0_wdata, m1_wdata  in  32  write data.
- m0_wstrb, m1_wstrb  in  4  byte write strobes; 0 means read.
- m0_ready, m1_ready  out  1  single-cycle completion to the master.
- m0_rdata, m1_rdata  out  32  read data; valid only while that master's ready is high, 0 otherwise.
- s_valid  out  1  request to the slave fabric.
- s_addr, s_wdata  out  32  granted master's addr/wdata; 0 when not busy.
- s_wstrb  out  4  granted master's wstrb; 0 when not busy.
- s_ready  in  1  slave completion.
- s_rdata  in  32  slave read data.
- owner  out  1  granted master index; holds the last owner while idle.
- busy  out  1  a transaction is granted.
- timeout  out  1  one-cycle pulse on a forced completion.
- err_addr  out  32  address of the most recent timed-out transaction.
- err_count  out  8  timeout count; saturates at 255.

## Operation
- States: IDLE, BUSY.
- IDLE, no request: stay in IDLE.
- IDLE, exactly one mX_valid: grant X, owner<=X, go to BUSY.
- IDLE, both valid: grant the master that is not the last served (round-robin).
- The last-served register resets to 1, so master 0 wins the first tie.
- BUSY, bus pass-through: s_valid = m[owner]_valid, and s_addr/s_wdata/s_wstrb are combinational copies of the owner's signals.
- BUSY, slave completion: on s_valid && s_ready, m[owner]_ready=1 and m[owner]_rdata=s_rdata in the same cycle. Then last<=owner and the state returns to IDLE.
- The non-owner master never sees ready; its request waits.
- BUSY, owner drops valid before ready (protocol abort): s_valid follows it low, no ready is issued, and the state returns to IDLE next cycle.
- Timeout counter: 16 bits, cleared on entry to BUSY, incremented each BUSY cycle that does not complete.
- Forced completion: when the counter equals TIMEOUT_CYCLES (nonzero), that cycle:
  - drives s_valid=0;
  - drives m[owner]_ready=1 with m[owner]_rdata=TIMEOUT_RDATA;
  - pulses timeout, loads err_addr<=s_addr-of-owner and increments err_count (saturating);
  - returns to IDLE with last<=owner.
- Because s_valid is 0 in the forced-completion cycle, s_ready in that cycle is ignored. A slave ready in the cycle before wins, and no timeout occurs.
- Write timeouts complete like reads; the data is discarded.

## Timing
- Grant latency: mX_valid seen in IDLE, so s_valid is high on the next cycle.
- Zero-wait slave: one transaction every 2 cycles (IDLE, BUSY).
- Slave ready to master ready: combinational, 0 cycles.
- Back-to-back: a master re-asserting valid the cycle after its ready is arbitrated in that IDLE cycle, against the other master under round-robin.
- Reset (asynchronous, any time, including mid-transaction):
  - state IDLE, owner 0, last 1, counter 0;
  - busy 0, s_valid 0, m0_ready/m1_ready 0, timeout 0;
  - err_addr 0, err_count 0.
  - The aborted transaction is not completed; masters are reset together with the arbiter.
- Only one of m0_ready/m1_ready is ever high in a cycle; neither is high in IDLE.

## Test plan
- Single master: m0 reads 0x0000_0010, slave ready 2 cycles after s_valid with rdata 0x1234_5678. Required: s_valid high 3 cycles, m0_ready one pulse with 0x1234_5678, m1_ready never high.
- Simultaneous requests from reset: m0 and m1 held valid for 4 transactions, zero-wait slave. Required grant order m0, m1, m0, m1 and owner toggling each grant.
- Write pass-through: m1 writes 0xA5A5_A5A5 to 0x8001_0000 with wstrb 4'b0011. Required: s_addr/s_wdata/s_wstrb match exactly during BUSY and are 0 in IDLE.
- Timeout: TIMEOUT_CYCLES=8, m0 reads 0x8004_0000 and s_ready is never asserted. Required: on the 9th BUSY cycle m0_ready=1 with rdata 0xFFFF_FFFF, timeout pulses, err_addr=0x8004_0000, err_count=1.
- Boundary: TIMEOUT_CYCLES=8 with s_ready arriving on BUSY cycle 8 (counter 7). Required: normal completion with slave data and no timeout pulse.
- Reset mid-transaction: assert rst during BUSY with s_valid high. Required: in the same cycle s_valid=0, busy=0, no master ready; after release the first tie goes to m0.
